// File: rtl/pad_mux_arbiter.sv
// Round-robin owner arbitration for one shared bidirectional pad cell.
// Every ownership change passes through a forced high-Z turnaround window.
module pad_mux_arbiter #(
    parameter int NREQ       = 2,
    parameter int PADATTR    = 16,
    parameter int TURNAROUND = 2,
    parameter logic [((PADATTR == 0) ? 1 : PADATTR)-1:0] PAD_ATTR_RST = '0
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NREQ-1:0]                               req_i,
    output logic [NREQ-1:0]                               gnt_o,
    input  logic [NREQ-1:0]                               oe_i,
    input  logic [NREQ-1:0]                               out_i,
    input  logic [NREQ*((PADATTR == 0) ? 1 : PADATTR)-1:0] attr_i,
    output logic [NREQ-1:0]                               in_o,
    output logic                                          pad_out_o,
    output logic                                          pad_oe_o,
    input  logic                                          pad_in_i,
    output logic [((PADATTR == 0) ? 1 : PADATTR)-1:0]     pad_attributes_o,
    output logic                                          busy_o,
    output logic [$clog2(NREQ)-1:0]                       owner_o
);
    localparam int AW = (PADATTR == 0) ? 1 : PADATTR;
    localparam int OW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [OW-1:0]   owner_nxt, ptr, ptr_nxt, winner;
    logic [3:0]      cnt, cnt_nxt;
    logic            win_vld;
    logic [AW-1:0]   owner_attr;
    int              idx;

    assign owner_attr = attr_i[int'(owner_o)*AW +: AW];
    assign busy_o     = (state != IDLE);

    // Scan downward so the last hit is the first requester at/after ptr.
    always_comb begin
        winner  = ptr;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = NREQ-1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req_i[idx]) begin
                winner  = OW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_o;
        owner_nxt = owner_o;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt       = GRANT;
                    gnt_nxt         = '0;
                    gnt_nxt[winner] = 1'b1;
                    owner_nxt       = winner;
                end
            end
            GRANT: begin
                if (!req_i[owner_o]) begin
                    gnt_nxt = '0;
                    ptr_nxt = (int'(owner_o) == NREQ-1) ? '0 : OW'(int'(owner_o) + 1);
                    if (TURNAROUND > 0) begin
                        state_nxt = TURN;
                        cnt_nxt   = 4'(TURNAROUND - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            TURN: begin
                if (cnt == 4'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            gnt_o   <= '0;
            owner_o <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            gnt_o   <= gnt_nxt;
            owner_o <= owner_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // The pad keeps the last owner's attributes while floating in TURN.
    always_comb begin
        pad_oe_o         = 1'b0;
        pad_out_o        = 1'b0;
        pad_attributes_o = PAD_ATTR_RST;
        in_o             = '0;
        case (state)
            GRANT: begin
                pad_oe_o         = oe_i[owner_o];
                pad_out_o        = out_i[owner_o];
                pad_attributes_o = owner_attr;
                in_o[owner_o]    = pad_in_i;
            end
            TURN:    pad_attributes_o = owner_attr;
            default: ;
        endcase
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(gnt_o)) else $error("gnt_o not onehot0");
            assert (!(pad_oe_o && state != GRANT)) else $error("pad_oe_o high outside GRANT");
        end
    end
endmodule

// File: tb/tb_pad_mux_arbiter.sv
// Bench for pad_mux_arbiter: a TURNAROUND=2 and a TURNAROUND=0 instance share stimulus
// and are compared against a tenure/quiet-time model, plus directed vectors.
module tb_pad_mux_arbiter;
    localparam logic [15:0] RST_A = 16'h0F0F;
    localparam logic [15:0] A0    = 16'hA5A5;
    localparam logic [15:0] A1    = 16'h3C3C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, oe, out;
    logic        pin;
    logic [31:0] attr;

    logic [1:0]  a_gnt, a_in, b_gnt, b_in;
    logic        a_pout, a_poe, a_busy, a_owner, b_pout, b_poe, b_busy, b_owner;
    logic [15:0] a_attr, b_attr;

    int checks = 0, failures = 0;

    // model: per instance, whether someone holds the pad, who, rr pointer, remaining quiet edges
    int m_hold[2], m_owner[2], m_ptr[2], m_quiet[2];
    int TAS[2] = '{2, 0};

    pad_mux_arbiter #(.NREQ(2), .PADATTR(16), .TURNAROUND(2), .PAD_ATTR_RST(RST_A)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(a_gnt), .oe_i(oe), .out_i(out),
        .attr_i(attr), .in_o(a_in), .pad_out_o(a_pout), .pad_oe_o(a_poe), .pad_in_i(pin),
        .pad_attributes_o(a_attr), .busy_o(a_busy), .owner_o(a_owner));

    pad_mux_arbiter #(.NREQ(2), .PADATTR(16), .TURNAROUND(0), .PAD_ATTR_RST(RST_A)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(b_gnt), .oe_i(oe), .out_i(out),
        .attr_i(attr), .in_o(b_in), .pad_out_o(b_pout), .pad_oe_o(b_poe), .pad_in_i(pin),
        .pad_attributes_o(b_attr), .busy_o(b_busy), .owner_o(b_owner));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req, oe, out; logic pin;
        logic [1:0] gnt; logic poe, pout; logic [1:0] in; logic [15:0] at; logic busy;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_quiet[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (m_hold[k] != 0) begin
                if (!req[m_owner[k]]) begin
                    m_hold[k]  = 0;
                    m_ptr[k]   = (m_owner[k] + 1) % 2;
                    m_quiet[k] = TAS[k];
                end
            end else if (m_quiet[k] > 0) begin
                m_quiet[k]--;
            end else begin
                for (int j = 1; j >= 0; j--)
                    if (req[(m_ptr[k] + j) % 2]) begin
                        m_owner[k] = (m_ptr[k] + j) % 2;
                        m_hold[k]  = 1;
                    end
            end
        end
    endtask

    task automatic chk_dut(string tag, int k, logic [1:0] g, logic po, logic pout,
                           logic [1:0] in, logic [15:0] at, logic bz, logic ow);
        logic h, q;
        h = (m_hold[k] != 0);
        q = h || (m_quiet[k] > 0);
        chk({tag, ".gnt"},  32'(g),    h ? 32'(1 << m_owner[k]) : 32'd0);
        chk({tag, ".oe"},   32'(po),   32'(h && oe[m_owner[k]]));
        chk({tag, ".out"},  32'(pout), 32'(h && out[m_owner[k]]));
        chk({tag, ".in"},   32'(in),   h ? 32'(32'(pin) << m_owner[k]) : 32'd0);
        chk({tag, ".attr"}, 32'(at),   q ? 32'(attr[m_owner[k]*16 +: 16]) : 32'(RST_A));
        chk({tag, ".busy"}, 32'(bz),   32'(q));
        chk({tag, ".own"},  32'(ow),   32'(m_owner[k]));
    endtask

    task automatic apply(logic [1:0] r, logic [1:0] o, logic [1:0] d, logic p);
        req = r; oe = o; out = d; pin = p;
        #1;
        chk_dut("a", 0, a_gnt, a_poe, a_pout, a_in, a_attr, a_busy, a_owner);
        chk_dut("b", 1, b_gnt, b_poe, b_pout, b_in, b_attr, b_busy, b_owner);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int hold_cnt;
        int gq[$];
        logic [1:0] prev_g, r;

        tbl[0] = '{2'b01, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, RST_A, 1'b0};
        tbl[1] = '{2'b01, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, A0,    1'b1};
        tbl[2] = '{2'b01, 2'b10, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, A0,    1'b1};
        tbl[3] = '{2'b11, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, A0,    1'b1};
        tbl[4] = '{2'b10, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, A0,    1'b1};
        tbl[5] = '{2'b11, 2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, A0,    1'b1};
        tbl[6] = '{2'b11, 2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, A0,    1'b1};
        tbl[7] = '{2'b11, 2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, RST_A, 1'b0};
        tbl[8] = '{2'b11, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, A1,    1'b1};

        rst_n = 1'b0; req = '0; oe = 2'b11; out = 2'b11; pin = 1'b1; attr = {A1, A0};
        model_reset();
        #3;
        chk("rst.poe",  32'(a_poe),  32'd0);
        chk("rst.gnt",  32'(a_gnt),  32'd0);
        chk("rst.attr", 32'(a_attr), 32'(RST_A));
        chk("rst.in",   32'(a_in),   32'd0);
        chk("rst.busy", 32'(a_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // directed vectors: first grant, non-owner ignored, release and turnaround gap
        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].req, tbl[i].oe, tbl[i].out, tbl[i].pin);
            chk($sformatf("tbl%0d.gnt", i),  32'(a_gnt),  32'(tbl[i].gnt));
            chk($sformatf("tbl%0d.oe", i),   32'(a_poe),  32'(tbl[i].poe));
            chk($sformatf("tbl%0d.out", i),  32'(a_pout), 32'(tbl[i].pout));
            chk($sformatf("tbl%0d.in", i),   32'(a_in),   32'(tbl[i].in));
            chk($sformatf("tbl%0d.attr", i), 32'(a_attr), 32'(tbl[i].at));
            chk($sformatf("tbl%0d.busy", i), 32'(a_busy), 32'(tbl[i].busy));
            tick();
        end

        // both held, each owner releases after 4 granted cycles: owners must alternate
        hold_cnt = 0; prev_g = a_gnt;
        for (int c = 0; c < 45; c++) begin
            if (a_gnt != 2'b00 && prev_g == 2'b00) gq.push_back(a_owner ? 1 : 0);
            hold_cnt = (a_gnt != 2'b00) ? hold_cnt + 1 : 0;
            prev_g = a_gnt;
            r = (a_gnt != 2'b00 && hold_cnt > 4) ? (~a_gnt & 2'b11) : 2'b11;
            apply(r, 2'b11, 2'b01, 1'b0);
            tick();
        end
        chk("alt.count", 32'(gq.size() >= 4), 32'd1);
        for (int i = 1; i < gq.size(); i++)
            chk($sformatf("alt.seq%0d", i), 32'(gq[i]), 32'(1 - gq[i-1]));

        // TURNAROUND=0 instance: release by 0 with 1 waiting -> one IDLE cycle then grant 1
        repeat (6) begin apply(2'b00, 2'b00, 2'b00, 1'b0); tick(); end
        apply(2'b01, 2'b01, 2'b01, 1'b0); tick();
        apply(2'b11, 2'b01, 2'b01, 1'b0);
        chk("t0.own", 32'(b_gnt), 32'b01);
        tick();
        apply(2'b10, 2'b01, 2'b01, 1'b0); tick();
        apply(2'b10, 2'b10, 2'b10, 1'b0);
        chk("t0.idle.gnt",  32'(b_gnt),  32'b00);
        chk("t0.idle.busy", 32'(b_busy), 32'd0);
        chk("t2.turn.busy", 32'(a_busy), 32'd1);
        tick();
        apply(2'b10, 2'b10, 2'b10, 1'b0);
        chk("t0.gnt1", 32'(b_gnt), 32'b10);
        chk("t0.oe1",  32'(b_poe), 32'd1);
        tick();

        // async reset mid-tenure of requester 1 (pointer at 1) then restart from pointer 0
        repeat (3) begin apply(2'b10, 2'b11, 2'b11, 1'b1); tick(); end
        apply(2'b11, 2'b11, 2'b11, 1'b1);
        chk("pre.rst.oe", 32'(a_poe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst.a.oe",   32'(a_poe),  32'd0);
        chk("arst.a.gnt",  32'(a_gnt),  32'd0);
        chk("arst.a.attr", 32'(a_attr), 32'(RST_A));
        chk("arst.b.oe",   32'(b_poe),  32'd0);
        chk("arst.b.busy", 32'(b_busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply(2'b11, 2'b11, 2'b11, 1'b1); tick();
        apply(2'b11, 2'b11, 2'b11, 1'b1);
        chk("restart.a.gnt", 32'(a_gnt), 32'b01);
        chk("restart.b.gnt", 32'(b_gnt), 32'b01);
        tick();

        // randomized: sticky requests so tenures last several cycles
        r = 2'b11;
        for (int c = 0; c < 600; c++) begin
            for (int j = 0; j < 2; j++) if ($urandom_range(0, 5) == 0) r[j] = ~r[j];
            if ($urandom_range(0, 7) == 0) attr = $urandom;
            apply(r, 2'($urandom), 2'($urandom), 1'($urandom));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
